// File: rtl/uart_tx_sched.sv
// uart_tx_sched: two per-port byte FIFOs feeding one UART transmitter.
// A three-state scheduler (IDLE -> ISSUE -> SETTLE) pops one byte at a time,
// alternating between ports when both have data. It waits while the
// transmitter reports busy. Overflowed pushes are dropped and flagged.
module uart_tx_sched #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       resetq,
   input  logic       req0_wr,
   input  logic [7:0] req0_data,
   input  logic       req1_wr,
   input  logic [7:0] req1_data,
   output logic       req0_full,
   output logic       req1_full,
   output logic       ovf0,
   output logic       ovf1,
   input  logic       ovf_clr,
   output logic       uart_wr,
   output logic [7:0] uart_data,
   input  logic       uart_busy,
   output logic       grant,
   output logic       idle
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_SETTLE = 2'd2
   } state_t;

   // Per-port views of the request interface, indexed by port number
   logic [1:0] wr_in;
   logic [7:0] data_in [2];
   logic [1:0] full;
   logic [1:0] nonempty;
   logic [1:0] push;
   logic [1:0] drop;
   logic [1:0] pop;
   logic [7:0] head [2];
   logic [1:0] ovf_q;
   logic [1:0] ovf_d;

   assign wr_in      = {req1_wr, req0_wr};
   assign data_in[0] = req0_data;
   assign data_in[1] = req1_data;

   for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      logic [7:0]    mem [DEPTH];
      logic [AW-1:0] wr_ptr_q;
      logic [AW-1:0] wr_ptr_d;
      logic [AW-1:0] rd_ptr_q;
      logic [AW-1:0] rd_ptr_d;
      logic [CW-1:0] count_q;
      logic [CW-1:0] count_d;

      // A full FIFO refuses the push even if it is popped in the same cycle
      assign full[gi]     = (count_q == CW'(DEPTH));
      assign nonempty[gi] = (count_q != '0);
      assign push[gi]     = wr_in[gi] & ~full[gi];
      assign drop[gi]     = wr_in[gi] & full[gi];
      assign head[gi]     = mem[rd_ptr_q];

      // Overflow is sticky; a fresh drop beats a simultaneous clear
      assign ovf_d[gi] = drop[gi] | (ovf_q[gi] & ~ovf_clr);

      // Next pointers and occupancy; pointers wrap naturally at DEPTH
      always_comb begin
         wr_ptr_d = wr_ptr_q;
         rd_ptr_d = rd_ptr_q;
         count_d  = count_q;
         if (push[gi]) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop[gi]) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push[gi], pop[gi]})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end

      // FIFO bookkeeping registers and overflow flag
      always_ff @(posedge clk or negedge resetq) begin
         if (!resetq) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q[gi] <= 1'b0;
         end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q[gi] <= ovf_d[gi];
         end
      end

      // Byte storage; contents need no reset since occupancy is tracked by count
      always_ff @(posedge clk) begin
         if (push[gi]) begin
            mem[wr_ptr_q] <= data_in[gi];
         end
      end
   end

   state_t     state_q;
   state_t     state_d;
   logic       uart_wr_q;
   logic       uart_wr_d;
   logic [7:0] uart_data_q;
   logic [7:0] uart_data_d;
   logic       grant_q;
   logic       grant_d;
   logic       sel;

   // Scheduler next-state: pick a port, pop it, and latch its byte on entry to ISSUE
   always_comb begin
      state_d     = state_q;
      uart_wr_d   = 1'b0;
      uart_data_d = uart_data_q;
      grant_d     = grant_q;
      pop         = '0;
      sel         = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!uart_busy && (|nonempty)) begin
               // Both waiting: take the port that did not go last
               if (&nonempty) begin
                  sel = ~grant_q;
               end else begin
                  sel = nonempty[1];
               end
               pop[sel]    = 1'b1;
               uart_data_d = head[sel];
               grant_d     = sel;
               uart_wr_d   = 1'b1;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE:  state_d = S_SETTLE;
         S_SETTLE: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Scheduler state and registered UART-side outputs
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         state_q     <= S_IDLE;
         uart_wr_q   <= 1'b0;
         uart_data_q <= 8'h00;
         grant_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         uart_wr_q   <= uart_wr_d;
         uart_data_q <= uart_data_d;
         grant_q     <= grant_d;
      end
   end

   assign req0_full = full[0];
   assign req1_full = full[1];
   assign ovf0      = ovf_q[0];
   assign ovf1      = ovf_q[1];
   assign uart_wr   = uart_wr_q;
   assign uart_data = uart_data_q;
   assign grant     = grant_q;
   assign idle      = ~(|nonempty) & (state_q == S_IDLE) & ~uart_busy;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed testbench for uart_tx_sched with a simple UART busy model.
module tb_uart_tx_sched;

   logic       clk = 1'b0;
   logic       resetq;
   logic       req0_wr;
   logic [7:0] req0_data;
   logic       req1_wr;
   logic [7:0] req1_data;
   logic       req0_full;
   logic       req1_full;
   logic       ovf0;
   logic       ovf1;
   logic       ovf_clr;
   logic       uart_wr;
   logic [7:0] uart_data;
   logic       uart_busy;
   logic       grant;
   logic       idle;

   logic       busy_force;
   logic       model_en;
   int         busy_cnt = 0;
   logic [7:0] issued [$];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx_sched #(.DEPTH(4)) dut (
      .clk       (clk),
      .resetq    (resetq),
      .req0_wr   (req0_wr),
      .req0_data (req0_data),
      .req1_wr   (req1_wr),
      .req1_data (req1_data),
      .req0_full (req0_full),
      .req1_full (req1_full),
      .ovf0      (ovf0),
      .ovf1      (ovf1),
      .ovf_clr   (ovf_clr),
      .uart_wr   (uart_wr),
      .uart_data (uart_data),
      .uart_busy (uart_busy),
      .grant     (grant),
      .idle      (idle)
   );

   // UART model: busy for 10 cycles starting the cycle after each strobe
   assign uart_busy = model_en ? (busy_cnt != 0) : busy_force;

   always @(posedge clk) begin
      if (uart_wr === 1'b1) busy_cnt <= 10;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end

   // Record every issued byte, one line per transaction
   always @(posedge clk) begin
      if (uart_wr === 1'b1) begin
         issued.push_back(uart_data);
         $display("[%0t] issue byte %h grant %b", $time, uart_data, grant);
      end
   end

   task automatic apply_reset();
      @(negedge clk);
      resetq = 1'b0; req0_wr = 1'b0; req1_wr = 1'b0; ovf_clr = 1'b0;
      model_en = 1'b0; busy_force = 1'b0;
      repeat (2) @(negedge clk);
      resetq = 1'b1;
      @(negedge clk);
   endtask

   task automatic push(input int port, input logic [7:0] d);
      @(negedge clk);
      if (port == 0) begin req0_wr = 1'b1; req0_data = d; end
      else begin req1_wr = 1'b1; req1_data = d; end
      @(negedge clk);
      req0_wr = 1'b0; req1_wr = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (uart_wr !== 1'b0) begin errors++; $display("FAIL rst_uart_wr: got %b expected 0", uart_wr); end
      checks++; if (uart_data !== 8'h00) begin errors++; $display("FAIL rst_uart_data: got %h expected 00", uart_data); end
      checks++; if (grant !== 1'b1) begin errors++; $display("FAIL rst_grant: got %b expected 1", grant); end
      checks++; if (ovf0 !== 1'b0 || ovf1 !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b%b expected 00", ovf1, ovf0); end
      checks++; if (req0_full !== 1'b0 || req1_full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b%b expected 00", req1_full, req0_full); end
      @(negedge clk);
      resetq = 1'b1;
      @(negedge clk);
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b expected 1", idle); end
      checks++; if (grant !== 1'b1) begin errors++; $display("FAIL rst_grant_after: got %b expected 1", grant); end
   endtask

   task automatic test_single_byte();
      apply_reset();
      push(0, 8'h41);
      checks++; if (uart_wr !== 1'b0) begin errors++; $display("FAIL single_n1_wr: got %b expected 0", uart_wr); end
      @(negedge clk);
      checks++; if (uart_wr !== 1'b1) begin errors++; $display("FAIL single_n2_wr: got %b expected 1", uart_wr); end
      checks++; if (uart_data !== 8'h41) begin errors++; $display("FAIL single_data: got %h expected 41", uart_data); end
      checks++; if (grant !== 1'b0) begin errors++; $display("FAIL single_grant: got %b expected 0", grant); end
      @(negedge clk);
      checks++; if (uart_wr !== 1'b0) begin errors++; $display("FAIL single_n3_wr: got %b expected 0", uart_wr); end
      checks++; if (uart_data !== 8'h41) begin errors++; $display("FAIL single_hold: got %h expected 41", uart_data); end
      @(negedge clk);
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle: got %b expected 1", idle); end
   endtask

   task automatic test_contention();
      logic [7:0] exp_b [4] = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
      logic [7:0] got;
      int base;
      apply_reset();
      busy_force = 1'b1;
      @(negedge clk);
      req0_wr = 1'b1; req0_data = 8'hA0; req1_wr = 1'b1; req1_data = 8'hB0;
      @(negedge clk);
      req0_data = 8'hA1; req1_data = 8'hB1;
      @(negedge clk);
      req0_wr = 1'b0; req1_wr = 1'b0;
      base = issued.size();
      model_en = 1'b1;
      for (int i = 0; i < 200 && issued.size() < base + 4; i++) @(negedge clk);
      checks++; if (issued.size() != base + 4) begin errors++; $display("FAIL contention_count: got %0d expected 4", issued.size() - base); end
      for (int i = 0; i < 4; i++) begin
         got = (base + i < issued.size()) ? issued[base + i] : 8'hxx;
         checks++; if (got !== exp_b[i]) begin errors++; $display("FAIL contention_order[%0d]: got %h expected %h", i, got, exp_b[i]); end
      end
      checks++; if (grant !== 1'b1) begin errors++; $display("FAIL contention_grant: got %b expected 1", grant); end
   endtask

   task automatic test_overflow();
      logic [7:0] got;
      int base;
      apply_reset();
      busy_force = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         req1_wr = 1'b1; req1_data = 8'h10 + 8'(i);
      end
      @(negedge clk);
      checks++; if (req1_full !== 1'b1) begin errors++; $display("FAIL ovf_full4: got %b expected 1", req1_full); end
      checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL ovf_before_drop: got %b expected 0", ovf1); end
      req1_data = 8'h14;
      @(negedge clk);
      req1_wr = 1'b0;
      checks++; if (ovf1 !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", ovf1); end
      checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL ovf_other: got %b expected 0", ovf0); end
      req1_wr = 1'b1; req1_data = 8'h15; ovf_clr = 1'b1;
      @(negedge clk);
      req1_wr = 1'b0;
      checks++; if (ovf1 !== 1'b1) begin errors++; $display("FAIL ovf_priority: got %b expected 1", ovf1); end
      @(negedge clk);
      ovf_clr = 1'b0;
      checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", ovf1); end
      base = issued.size();
      model_en = 1'b1;
      for (int i = 0; i < 200 && issued.size() < base + 4; i++) @(negedge clk);
      repeat (30) @(negedge clk);
      checks++; if (issued.size() != base + 4) begin errors++; $display("FAIL ovf_issue_count: got %0d expected 4", issued.size() - base); end
      for (int i = 0; i < 4; i++) begin
         got = (base + i < issued.size()) ? issued[base + i] : 8'hxx;
         checks++; if (got !== 8'h10 + 8'(i)) begin errors++; $display("FAIL ovf_order[%0d]: got %h expected %h", i, got, 8'h10 + 8'(i)); end
      end
   endtask

   task automatic test_full_pop();
      logic [7:0] got;
      int base;
      apply_reset();
      busy_force = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         req0_wr = 1'b1; req0_data = 8'h20 + 8'(i);
      end
      @(negedge clk);
      req0_wr = 1'b0;
      checks++; if (req0_full !== 1'b1) begin errors++; $display("FAIL fullpop_full: got %b expected 1", req0_full); end
      base = issued.size();
      @(negedge clk);
      busy_force = 1'b0; req0_wr = 1'b1; req0_data = 8'h99;
      @(negedge clk);
      req0_wr = 1'b0;
      checks++; if (ovf0 !== 1'b1) begin errors++; $display("FAIL fullpop_ovf: got %b expected 1", ovf0); end
      checks++; if (req0_full !== 1'b0) begin errors++; $display("FAIL fullpop_count3: got full=%b expected 0", req0_full); end
      checks++; if (uart_wr !== 1'b1 || uart_data !== 8'h20) begin errors++; $display("FAIL fullpop_issue: got wr=%b data=%h expected wr=1 data=20", uart_wr, uart_data); end
      for (int i = 0; i < 50 && issued.size() < base + 4; i++) @(negedge clk);
      repeat (20) @(negedge clk);
      checks++; if (issued.size() != base + 4) begin errors++; $display("FAIL fullpop_total: got %0d expected 4", issued.size() - base); end
      for (int i = 0; i < 4; i++) begin
         got = (base + i < issued.size()) ? issued[base + i] : 8'hxx;
         checks++; if (got !== 8'h20 + 8'(i)) begin errors++; $display("FAIL fullpop_order[%0d]: got %h expected %h", i, got, 8'h20 + 8'(i)); end
      end
   endtask

   task automatic test_busy_gating();
      int base;
      apply_reset();
      busy_force = 1'b1;
      @(negedge clk);
      req0_wr = 1'b1; req0_data = 8'h55; req1_wr = 1'b1; req1_data = 8'h66;
      @(negedge clk);
      req0_wr = 1'b0; req1_wr = 1'b0;
      base = issued.size();
      repeat (50) @(negedge clk);
      checks++; if (issued.size() != base) begin errors++; $display("FAIL gate_no_issue: got %0d strobes expected 0", issued.size() - base); end
      checks++; if (idle !== 1'b0) begin errors++; $display("FAIL gate_idle: got %b expected 0", idle); end
      busy_force = 1'b0;
      @(negedge clk);
      checks++; if (uart_wr !== 1'b1 || uart_data !== 8'h55) begin errors++; $display("FAIL gate_first: got wr=%b data=%h expected wr=1 data=55", uart_wr, uart_data); end
      @(negedge clk);
      checks++; if (uart_wr !== 1'b0) begin errors++; $display("FAIL gate_settle: got %b expected 0", uart_wr); end
      @(negedge clk);
      checks++; if (uart_wr !== 1'b0) begin errors++; $display("FAIL gate_idle_gap: got %b expected 0", uart_wr); end
      @(negedge clk);
      checks++; if (uart_wr !== 1'b1 || uart_data !== 8'h66 || grant !== 1'b1) begin errors++; $display("FAIL gate_second: got wr=%b data=%h grant=%b expected wr=1 data=66 grant=1", uart_wr, uart_data, grant); end
   endtask

   task automatic test_reset_mid();
      int  base;
      bit  found = 1'b0;
      apply_reset();
      busy_force = 1'b1;
      @(negedge clk);
      req0_wr = 1'b1; req0_data = 8'h30; req1_wr = 1'b1; req1_data = 8'h40;
      @(negedge clk);
      req0_data = 8'h31; req1_data = 8'h41;
      @(negedge clk);
      req0_wr = 1'b0; req1_wr = 1'b0;
      busy_force = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (uart_wr === 1'b1) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL midrst_reach_issue: got no strobe expected strobe"); end
      #1;
      resetq = 1'b0; busy_force = 1'b1;
      #1;
      checks++; if (uart_wr !== 1'b0) begin errors++; $display("FAIL midrst_wr: got %b expected 0", uart_wr); end
      checks++; if (uart_data !== 8'h00 || grant !== 1'b1) begin errors++; $display("FAIL midrst_regs: got data=%h grant=%b expected data=00 grant=1", uart_data, grant); end
      base = issued.size();
      @(negedge clk);
      resetq = 1'b1;
      repeat (5) @(negedge clk);
      checks++; if (idle !== 1'b0) begin errors++; $display("FAIL midrst_busy_idle: got %b expected 0", idle); end
      busy_force = 1'b0;
      @(negedge clk);
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL midrst_idle: got %b expected 1", idle); end
      repeat (10) @(negedge clk);
      checks++; if (issued.size() != base) begin errors++; $display("FAIL midrst_no_issue: got %0d strobes expected 0", issued.size() - base); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      resetq = 1'b1; req0_wr = 1'b0; req1_wr = 1'b0; req0_data = 8'h00; req1_data = 8'h00;
      ovf_clr = 1'b0; busy_force = 1'b0; model_en = 1'b0;
      #1 resetq = 1'b0;
      test_reset();
      test_single_byte();
      test_contention();
      test_overflow();
      test_full_pop();
      test_busy_gating();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
